program_loader: RTL and testbench

Instruction encoder and program-memory loader for the CPU: the write side of the instruction format the core's decoder consumes. It accepts decoded instruction fields over a valid/ready handshake and packs each set into a 16-bit instruction word. It writes the words to consecutive instruction-memory addresses starting at 0, tracking program length, completion and overflow. It sits between the host/test harness and the instruction memory feeding the CPU fetch path.

---
 rtl/program_loader.sv | 91 +++++++++
 tb/tb_program_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Instruction encoder and program-memory loader: packs decoded field sets into 16-bit
// instruction words and writes them to consecutive addresses starting at 0.
module program_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_const,
  input  logic [14:0]       constant,
  input  logic [1:0]        dest,
  input  logic              op1,
  input  logic [1:0]        op2,
  input  logic [3:0]        opCode,
  input  logic              jmpIfZ,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [15:0]       word;
  logic              accept;

  assign in_ready = (state == StLoad);
  assign busy     = (state == StLoad);
  assign accept   = in_valid && in_ready;

  always_comb begin
    word = 16'h0000;
    if (is_const) begin
      word = {1'b1, constant};
    end else begin
      word = {1'b0, dest, op1, op2, opCode, jmpIfZ, 5'b00000};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      ptr       <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 16'h0000;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        StLoad: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= word;
            ptr       <= ptr + 1'b1;
            count     <= count + 1'b1;
            // last wins over a simultaneous fill of the final address
            if (last) begin
              state <= StDone;
              done  <= 1'b1;
            end else if (&ptr) begin
              state    <= StErr;
              overflow <= 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            state    <= StLoad;
            ptr      <= '0;
            count    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a word-level reference model.
module tb_program_loader;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          start    = 1'b0;
  logic          in_valid = 1'b0;
  logic          is_const = 1'b0;
  logic [14:0]   constant = '0;
  logic [1:0]    dest     = '0;
  logic          op1      = 1'b0;
  logic [1:0]    op2      = '0;
  logic [3:0]    opCode   = '0;
  logic          jmpIfZ   = 1'b0;
  logic          last     = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic          overflow;

  int          vectors     = 0;
  int          miscompares = 0;
  int          last_addr   = 0;
  logic [15:0] last_word   = '0;

  program_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_const  (is_const),
    .constant  (constant),
    .dest      (dest),
    .op1       (op1),
    .op2       (op2),
    .opCode    (opCode),
    .jmpIfZ    (jmpIfZ),
    .last      (last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoding from the instruction format, by field weights.
  function automatic logic [15:0] model_word();
    int w;
    if (is_const) w = 32768 + int'(constant);
    else w = int'(dest) * 8192 + int'(op1) * 4096 + int'(op2) * 1024 + int'(opCode) * 64
             + int'(jmpIfZ) * 32;
    return 16'(w);
  endfunction

  task automatic rand_fields();
    is_const = 1'($urandom);
    constant = 15'($urandom);
    dest     = 2'($urandom);
    op1      = 1'($urandom);
    op2      = 2'($urandom);
    opCode   = 4'($urandom);
    jmpIfZ   = 1'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_count"}, count, 0);
  endtask

  task automatic do_reset();
    #($urandom_range(1, 4));
    rst_n = 1'b0;
    #1;
    check_all_zero("rst");
    in_valid = 1'b0;
    start    = 1'b0;
    last     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // IDLE ignores in_valid
    rand_fields();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", in_ready, 0);
    check("idle_we", mem_we, 0);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
    check("start_count", count, 0);
    check("start_done", done, 0);
    check("start_ovf", overflow, 0);
    check("start_we", mem_we, 0);
  endtask

  // Loads n words; the final one carries last when with_last, otherwise n must fill memory.
  task automatic run_load(input int n, input bit with_last, input bit gaps);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          rand_fields();
          @(posedge clk);
          #1;
          check("gap_we", mem_we, 0);
          check("gap_count", count, i);
          if (i > 0) begin
            check("hold_addr", mem_addr, last_addr);
            check("hold_data", mem_wdata, last_word);
          end
        end
      end
      rand_fields();
      in_valid = 1'b1;
      last     = with_last && (i == n - 1);
      start    = ($urandom_range(0, 3) == 0);
      w        = model_word();
      check("ready", in_ready, 1);
      @(posedge clk);
      #1;
      check("we", mem_we, 1);
      check("addr", mem_addr, i);
      check("wdata", mem_wdata, w);
      check("count", count, i + 1);
      last_addr = i;
      last_word = w;
    end
    in_valid = 1'b0;
    last     = 1'b0;
    start    = 1'b0;
    check("end_done", done, with_last);
    check("end_ovf", overflow, !with_last);
    check("end_busy", busy, 0);
    check("end_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      rand_fields();
      in_valid = 1'b1;
      last     = 1'($urandom);
      @(posedge clk);
      #1;
      check("post_we", mem_we, 0);
      check("post_count", count, n);
      check("post_done", done, with_last);
      check("post_ovf", overflow, !with_last);
      check("post_addr", mem_addr, last_addr);
    end
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  task automatic directed(input bit ic, input logic [14:0] c, input logic [1:0] d,
                          input bit o1, input logic [1:0] o2, input logic [3:0] op,
                          input bit j, input logic [15:0] exp);
    do_start();
    is_const = ic;
    constant = c;
    dest     = d;
    op1      = o1;
    op2      = o2;
    opCode   = op;
    jmpIfZ   = j;
    in_valid = 1'b1;
    last     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last     = 1'b0;
    check("dir_we", mem_we, 1);
    check("dir_addr", mem_addr, 0);
    check("dir_wdata", mem_wdata, exp);
    check("dir_done", done, 1);
    check("dir_count", count, 1);
    @(posedge clk);
    #1;
    check("dir_we_pulse", mem_we, 0);
  endtask

  initial begin
    do_reset();

    directed(1'b0, 15'h0000, 2'b11, 1'b1, 2'b10, 4'b0101, 1'b1, 16'h7960);
    directed(1'b1, 15'h1234, 2'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
             1'($urandom), 16'h9234);
    directed(1'b0, 15'($urandom), 2'b00, 1'b0, 2'b00, 4'b0000, 1'b1, 16'h0020);

    do_start();
    run_load(3, 1'b1, 1'b0);

    do_start();
    run_load(CAP, 1'b0, 1'b0);
    do_start();
    run_load(1, 1'b1, 1'b0);

    // Abort in the cycle after an accept
    do_start();
    rand_fields();
    in_valid = 1'b1;
    last     = 1'b0;
    @(posedge clk);
    #1;
    check("abort_pre_we", mem_we, 1);
    rand_fields();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("abort_hold");
    rst_n = 1'b1;
    do_start();
    run_load(2, 1'b1, 1'b0);

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      do_start();
      if ($urandom_range(0, 2) == 0) run_load(CAP, 1'b0, 1'($urandom));
      else run_load($urandom_range(1, CAP), 1'b1, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
